// File: rtl/button_events.sv
// Debounced front end for active-low push buttons.
// Per channel: two-flop synchroniser, debounce counter, press/release strobes and a
// hold strobe with auto-repeat. Channels are fully independent.
// The release strobe port is named 'rel' because 'release' is a reserved SystemVerilog keyword.
module button_events #(
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned LONG_CYCLES     = 13500000,
  parameter int unsigned REPEAT_CYCLES   = 2700000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] pressed,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] rel,
  output logic [NUM_BTN-1:0] hold
);

  localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HC_W     = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0] DB_TERM   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] LONG_TERM = HC_W'(LONG_CYCLES - 1);
  localparam logic [HC_W-1:0] REP_TERM  = HC_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWaitLong, StRepeat} hold_state_e;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic            sync1_q, sync2_q, sync;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            pressed_q, pressed_d;
    logic            flip, press_evt, rel_evt;
    logic            press_q, rel_q, hold_q, hold_d;
    hold_state_e     state_q, state_d;
    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;

    // Two-flop synchroniser on the raw pin; resets to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= btn_n[i];
        sync2_q <= sync1_q;
      end
    end

    assign sync = ~sync2_q;

    // Debounce: count consecutive cycles where sync disagrees with the accepted level.
    always_comb begin
      db_cnt_d  = '0;
      pressed_d = pressed_q;
      flip      = 1'b0;
      if (sync != pressed_q) begin
        if (db_cnt_q == DB_TERM) begin
          flip      = 1'b1;
          pressed_d = sync;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
    end

    assign press_evt = flip & sync;
    assign rel_evt   = flip & ~sync;

    // Hold FSM next state; a release overrides everything, including a due hold strobe.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = '0;
      hold_d     = 1'b0;
      case (state_q)
        StIdle: begin
          if (press_evt) state_d = StWaitLong;
        end
        StWaitLong: begin
          if (hold_cnt_q == LONG_TERM) begin
            hold_d  = 1'b1;
            state_d = StRepeat;
          end else begin
            hold_cnt_d = hold_cnt_q + HC_W'(1);
          end
        end
        StRepeat: begin
          if (hold_cnt_q == REP_TERM) begin
            hold_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HC_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
      if (rel_evt) begin
        state_d    = StIdle;
        hold_cnt_d = '0;
        hold_d     = 1'b0;
      end
    end

    // Channel state and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q   <= '0;
        pressed_q  <= 1'b0;
        press_q    <= 1'b0;
        rel_q      <= 1'b0;
        hold_q     <= 1'b0;
        state_q    <= StIdle;
        hold_cnt_q <= '0;
      end else begin
        db_cnt_q   <= db_cnt_d;
        pressed_q  <= pressed_d;
        press_q    <= press_evt;
        rel_q      <= rel_evt;
        hold_q     <= hold_d;
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
      end
    end

    assign pressed[i] = pressed_q;
    assign press[i]   = press_q;
    assign rel[i]     = rel_q;
    assign hold[i]    = hold_q;
  end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with a strobe scoreboard.
// Expected strobes (cycle + masks) are queued when stimulus is applied; a negedge monitor
// pops and compares them whenever the DUT shows any strobe.
module tb_button_events;

  localparam int unsigned NB = 2;

  typedef struct packed {
    int unsigned c;
    logic [1:0]  p;
    logic [1:0]  r;
    logic [1:0]  h;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NB-1:0] btn_n = '1;
  logic [NB-1:0] pressed, press, rel, hold;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  ev_t         q[$];

  button_events #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .REPEAT_CYCLES  (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_n  (btn_n),
    .pressed(pressed),
    .press  (press),
    .rel    (rel),
    .hold   (hold)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge k settles, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int unsigned c, logic [1:0] p, logic [1:0] r, logic [1:0] h);
    q.push_back(ev_t'{c: c, p: p, r: r, h: h});
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    ev_t obs, exp;
    if (rst_n) begin
      if (q.size() > 0 && q[0].c < cyc) begin
        checks++;
        errors++;
        $error("FAIL missed_strobe: got none expected cyc=%0d p=%b r=%b h=%b",
               q[0].c, q[0].p, q[0].r, q[0].h);
        void'(q.pop_front());
      end
      if ((press | rel | hold) != '0) begin
        obs = ev_t'{c: cyc, p: press, r: rel, h: hold};
        checks++;
        if (q.size() == 0) begin
          errors++;
          $error("FAIL unexpected_strobe: got cyc=%0d p=%b r=%b h=%b expected none",
                 obs.c, obs.p, obs.r, obs.h);
        end else begin
          exp = q.pop_front();
          assert (obs === exp) else begin
            errors++;
            $error("FAIL strobe: got cyc=%0d p=%b r=%b h=%b expected cyc=%0d p=%b r=%b h=%b",
                   obs.c, obs.p, obs.r, obs.h, exp.c, exp.p, exp.r, exp.h);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned e, f, r;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pressed", 32'(pressed), 32'h0);
    chk("rst_press", 32'(press), 32'h0);
    chk("rst_rel", 32'(rel), 32'h0);
    chk("rst_hold", 32'(hold), 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Clean press held into auto-repeat, then release.
    e = cyc;
    btn_n[0] = 1'b0;
    push(e + 6, 2'b01, 2'b00, 2'b00);
    push(e + 16, 2'b00, 2'b00, 2'b01);
    push(e + 19, 2'b00, 2'b00, 2'b01);
    push(e + 22, 2'b00, 2'b00, 2'b01);
    push(e + 25, 2'b00, 2'b00, 2'b01);
    wait_until(e + 5);
    chk("clean_pressed_before", 32'(pressed), 32'h0);
    wait_until(e + 6);
    chk("clean_pressed_at", 32'(pressed), 32'h1);
    wait_until(e + 26);
    btn_n[0] = 1'b1;
    push(e + 28, 2'b00, 2'b00, 2'b01);
    push(e + 31, 2'b00, 2'b00, 2'b01);
    push(e + 32, 2'b00, 2'b01, 2'b00);
    wait_until(e + 31);
    chk("long_pressed_still", 32'(pressed), 32'h1);
    wait_until(e + 32);
    chk("long_released", 32'(pressed), 32'h0);
    wait_until(e + 40);

    // Bounce rejection, then release inside the long-hold wait.
    e = cyc;
    btn_n[0] = 1'b0;
    wait_until(e + 3); btn_n[0] = 1'b1;
    wait_until(e + 4); btn_n[0] = 1'b0;
    wait_until(e + 6); btn_n[0] = 1'b1;
    wait_until(e + 7); btn_n[0] = 1'b0;
    push(e + 13, 2'b01, 2'b00, 2'b00);
    wait_until(e + 12);
    chk("bounce_pressed_before", 32'(pressed), 32'h0);
    wait_until(e + 13);
    chk("bounce_pressed_at", 32'(pressed), 32'h1);
    wait_until(e + 15);
    btn_n[0] = 1'b1;
    push(e + 21, 2'b00, 2'b01, 2'b00);
    wait_until(e + 30);
    chk("short_released", 32'(pressed), 32'h0);

    // Re-press restarts the long timer; reset mid-repeat.
    f = cyc;
    btn_n[0] = 1'b0;
    push(f + 6, 2'b01, 2'b00, 2'b00);
    push(f + 16, 2'b00, 2'b00, 2'b01);
    wait_until(f + 19);
    chk("repress_hold_before_rst", 32'(hold), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_pressed", 32'(pressed), 32'h0);
    chk("midrst_press", 32'(press), 32'h0);
    chk("midrst_rel", 32'(rel), 32'h0);
    chk("midrst_hold", 32'(hold), 32'h0);
    tick(3);
    rst_n = 1'b1;
    r = cyc;
    push(r + 6, 2'b01, 2'b00, 2'b00);
    wait_until(r + 5);
    chk("boot_pressed_before", 32'(pressed), 32'h0);
    wait_until(r + 6);
    chk("boot_pressed_at", 32'(pressed), 32'h1);
    wait_until(r + 7);
    btn_n[0] = 1'b1;
    push(r + 13, 2'b00, 2'b01, 2'b00);
    wait_until(r + 20);

    // Independent channels.
    e = cyc;
    btn_n = 2'b00;
    push(e + 6, 2'b11, 2'b00, 2'b00);
    wait_until(e + 6);
    chk("both_pressed", 32'(pressed), 32'h3);
    wait_until(e + 8);
    btn_n[1] = 1'b1;
    push(e + 14, 2'b00, 2'b10, 2'b00);
    push(e + 16, 2'b00, 2'b00, 2'b01);
    push(e + 19, 2'b00, 2'b00, 2'b01);
    push(e + 22, 2'b00, 2'b00, 2'b01);
    wait_until(e + 14);
    chk("ch1_released", 32'(pressed), 32'h1);
    wait_until(e + 23);
    btn_n[0] = 1'b1;
    push(e + 25, 2'b00, 2'b00, 2'b01);
    push(e + 28, 2'b00, 2'b00, 2'b01);
    push(e + 29, 2'b00, 2'b01, 2'b00);
    wait_until(e + 35);
    chk("all_released", 32'(pressed), 32'h0);
    chk("queue_empty", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
